// File: rtl/qspi_cs_sequencer_if.sv
// Request, configuration, controller and status signals of the QSPI chip-select sequencer.
// The sequencer sits on the slave modport; whoever issues requests uses the master modport.
interface qspi_cs_sequencer_if #(
    parameter int unsigned NSLAVE        = 4,
    parameter int unsigned DIVIDER_WIDTH = 8,
    parameter int unsigned TIMING_WIDTH  = 4
);
    localparam int unsigned SEL_W = $clog2(NSLAVE);
    localparam int unsigned CFG_W = 2 + DIVIDER_WIDTH + 3 * TIMING_WIDTH;

    logic                     cfg_we;
    logic [SEL_W-1:0]         cfg_sel;
    logic [CFG_W-1:0]         cfg_wdata;
    logic                     req_valid;
    logic [SEL_W-1:0]         req_cs;
    logic                     req_ready;
    logic                     req_err;
    logic                     ctrl_start;
    logic                     ctrl_cpol;
    logic                     ctrl_cpha;
    logic [DIVIDER_WIDTH-1:0] ctrl_dvsr;
    logic                     ctrl_done;
    logic [NSLAVE-1:0]        cs_n;
    logic                     busy;
    logic                     xfer_done;
    logic                     xfer_timeout;

    modport master (
        output cfg_we, cfg_sel, cfg_wdata, req_valid, req_cs, ctrl_done,
        input  req_ready, req_err, ctrl_start, ctrl_cpol, ctrl_cpha, ctrl_dvsr,
        input  cs_n, busy, xfer_done, xfer_timeout
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_wdata, req_valid, req_cs, ctrl_done,
        output req_ready, req_err, ctrl_start, ctrl_cpol, ctrl_cpha, ctrl_dvsr,
        output cs_n, busy, xfer_done, xfer_timeout
    );
endinterface

// File: rtl/qspi_cs_sequencer.sv
// Multi-slave chip-select sequencer: per-slave mode/divider/CS-timing table, one transfer at a
// time through setup, start, wait-for-done (with watchdog), hold and inter-transfer gap.
module qspi_cs_sequencer #(
    parameter int unsigned NSLAVE         = 4,
    parameter int unsigned DIVIDER_WIDTH  = 8,
    parameter int unsigned TIMING_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                clk,
    input logic                reset,
    qspi_cs_sequencer_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NSLAVE);
    localparam int unsigned CFG_W = 2 + DIVIDER_WIDTH + 3 * TIMING_WIDTH;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SEL_W:0]        NSLAVE_L = NSLAVE[SEL_W:0];
    localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMING_WIDTH-1:0] CNT_ONE = TIMING_WIDTH'(1);

    typedef struct packed {
        logic                     cpol;
        logic                     cpha;
        logic [DIVIDER_WIDTH-1:0] dvsr;
        logic [TIMING_WIDTH-1:0]  t_setup;
        logic [TIMING_WIDTH-1:0]  t_hold;
        logic [TIMING_WIDTH-1:0]  t_gap;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        cpol:    1'b0,
        cpha:    1'b0,
        dvsr:    DIVIDER_WIDTH'(1),
        t_setup: TIMING_WIDTH'(1),
        t_hold:  TIMING_WIDTH'(1),
        t_gap:   TIMING_WIDTH'(1)
    };

    typedef enum logic [2:0] {StIdle, StSetup, StStart, StXfer, StHold, StGap} state_e;

    state_e                  state_q, state_d;
    cfg_t                    cfg_tbl_q [NSLAVE];
    cfg_t                    cur_q, cur_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [TIMING_WIDTH-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    ok_q, ok_d;
    logic [NSLAVE-1:0]       cs_n_q, cs_n_d;
    logic                    req_err_q, req_err_d;
    logic                    xfer_done_q, xfer_done_d;
    logic                    xfer_timeout_q, xfer_timeout_d;
    logic                    cfg_sel_ok, req_cs_ok, cs_active;

    assign cfg_sel_ok = {1'b0, bus.cfg_sel} < NSLAVE_L;
    assign req_cs_ok  = {1'b0, bus.req_cs} < NSLAVE_L;

    // Accept reads the registered table, so a same-edge write is seen only by later requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NSLAVE); i++) begin
                cfg_tbl_q[i] <= CFG_RESET;
            end
        end else if (bus.cfg_we && cfg_sel_ok) begin
            cfg_tbl_q[bus.cfg_sel] <= cfg_t'(bus.cfg_wdata);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cur_q          <= CFG_RESET;
            sel_q          <= '0;
            cnt_q          <= '0;
            wd_q           <= '0;
            ok_q           <= 1'b0;
            cs_n_q         <= '1;
            req_err_q      <= 1'b0;
            xfer_done_q    <= 1'b0;
            xfer_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            ok_q           <= ok_d;
            cs_n_q         <= cs_n_d;
            req_err_q      <= req_err_d;
            xfer_done_q    <= xfer_done_d;
            xfer_timeout_q <= xfer_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        wd_d           = wd_q;
        ok_d           = ok_q;
        req_err_d      = 1'b0;
        xfer_done_d    = 1'b0;
        xfer_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_cs_ok) begin
                        sel_d = bus.req_cs;
                        cur_d = cfg_tbl_q[bus.req_cs];
                        if (cur_d.t_setup != '0) begin
                            state_d = StSetup;
                            cnt_d   = cur_d.t_setup;
                        end else begin
                            state_d = StStart;
                        end
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == CNT_ONE) state_d = StStart;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            StStart: begin
                state_d = StXfer;
                wd_d    = '0;
            end
            StXfer: begin
                // ctrl_done wins over a watchdog expiry in the same cycle.
                if (bus.ctrl_done || wd_q == WD_LAST) begin
                    ok_d           = bus.ctrl_done;
                    xfer_timeout_d = !bus.ctrl_done;
                    if (cur_q.t_hold != '0) begin
                        state_d = StHold;
                        cnt_d   = cur_q.t_hold;
                    end else begin
                        xfer_done_d = bus.ctrl_done;
                        if (cur_q.t_gap != '0) begin
                            state_d = StGap;
                            cnt_d   = cur_q.t_gap;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            StHold: begin
                if (cnt_q == CNT_ONE) begin
                    xfer_done_d = ok_q;
                    if (cur_q.t_gap != '0) begin
                        state_d = StGap;
                        cnt_d   = cur_q.t_gap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StGap: begin
                if (cnt_q == CNT_ONE) state_d = StIdle;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = StIdle;
        endcase

        // cs_n is registered from the next state so it never glitches and only one bit is low.
        cs_active = state_d inside {StSetup, StStart, StXfer, StHold};
        cs_n_d    = cs_active ? ~(NSLAVE'(1) << sel_d) : '1;
    end

    assign bus.req_ready    = (state_q == StIdle) && !reset;
    assign bus.req_err      = req_err_q;
    assign bus.ctrl_start   = (state_q == StStart);
    assign bus.ctrl_cpol    = cur_q.cpol;
    assign bus.ctrl_cpha    = cur_q.cpha;
    assign bus.ctrl_dvsr    = cur_q.dvsr;
    assign bus.cs_n         = cs_n_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.xfer_done    = xfer_done_q;
    assign bus.xfer_timeout = xfer_timeout_q;

    cs_onehot_a: assert property (@(posedge clk) disable iff (reset) $countones(~cs_n_q) <= 1);
endmodule

// File: tb/tb_qspi_cs_sequencer.sv
// Scoreboard bench for qspi_cs_sequencer: directed transfers push expected events into a
// queue; a negedge monitor pops and compares every event the DUT produces.
module tb_qspi_cs_sequencer;
    localparam int K_CS_ON   = 0;
    localparam int K_START   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_CS_OFF  = 3;
    localparam int K_DONE    = 4;
    localparam int K_IDLE    = 5;
    localparam int K_ERR3    = 6;
    localparam int K_ERR4    = 7;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] cs;
        logic       cpol;
        logic       cpha;
        logic [7:0] dvsr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic prev_cs_on = 1'b0;
    logic prev_busy = 1'b0;
    logic [3:0] prev_cs = 4'hF;

    qspi_cs_sequencer_if #(.NSLAVE(4), .DIVIDER_WIDTH(8), .TIMING_WIDTH(4)) bus4 ();
    qspi_cs_sequencer_if #(.NSLAVE(3), .DIVIDER_WIDTH(8), .TIMING_WIDTH(4)) bus3 ();

    qspi_cs_sequencer #(
        .NSLAVE(4), .DIVIDER_WIDTH(8), .TIMING_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );

    qspi_cs_sequencer #(
        .NSLAVE(3), .DIVIDER_WIDTH(8), .TIMING_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_CS_ON:   return "cs_on";
            K_START:   return "ctrl_start";
            K_TIMEOUT: return "xfer_timeout";
            K_CS_OFF:  return "cs_off";
            K_DONE:    return "xfer_done";
            K_IDLE:    return "idle";
            K_ERR3:    return "req_err3";
            default:   return "req_err4";
        endcase
    endfunction

    function automatic logic [21:0] cfg(input logic cpol, cpha, input logic [7:0] dvsr,
                                        input int ts, th, tg);
        logic [3:0] s, h, g;
        s = 4'(ts);
        h = 4'(th);
        g = 4'(tg);
        return {cpol, cpha, dvsr, s, h, g};
    endfunction

    function automatic logic [3:0] cs_pat(input int cs);
        logic [3:0] one;
        one = 4'b0001 << cs;
        return ~one;
    endfunction

    task automatic push(input int kind, input int c, input logic [3:0] cs,
                        input logic cpol, cpha, input logic [7:0] dvsr);
        exp_t e;
        e.kind = kind; e.cyc = c; e.cs = cs; e.cpol = cpol; e.cpha = cpha; e.dvsr = dvsr;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, expected none", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got %s@%0d expected %s@%0d",
                     kname(kind), cyc, kname(e.kind), e.cyc);
        end else if (kind == K_START && {bus4.ctrl_cpol, bus4.ctrl_cpha, bus4.ctrl_dvsr} !==
                                        {e.cpol, e.cpha, e.dvsr}) begin
            errors++;
            $display("FAIL start_cfg: got cpol=%0b cpha=%0b dvsr=%0h expected %0b %0b %0h",
                     bus4.ctrl_cpol, bus4.ctrl_cpha, bus4.ctrl_dvsr, e.cpol, e.cpha, e.dvsr);
        end else if (kind == K_CS_ON && bus4.cs_n !== e.cs) begin
            errors++;
            $display("FAIL cs_on_value: got %b expected %b", bus4.cs_n, e.cs);
        end
    endtask

    // Monitor: event order within a cycle is fixed and matches the order stimulus pushes them.
    always @(negedge clk) begin
        logic cs_on;
        cs_on = (bus4.cs_n !== 4'hF);
        if (cs_on && !prev_cs_on) check_evt(K_CS_ON);
        if (cs_on && prev_cs_on) chk("cs_stable", 32'(bus4.cs_n), 32'(prev_cs));
        if (bus4.ctrl_start) check_evt(K_START);
        if (bus4.xfer_timeout) check_evt(K_TIMEOUT);
        if (!cs_on && prev_cs_on) check_evt(K_CS_OFF);
        if (bus4.xfer_done) check_evt(K_DONE);
        if (!bus4.busy && prev_busy) check_evt(K_IDLE);
        if (bus3.req_err) check_evt(K_ERR3);
        if (bus4.req_err) check_evt(K_ERR4);
        prev_cs_on = cs_on;
        prev_cs    = bus4.cs_n;
        prev_busy  = bus4.busy;
    end

    task automatic write_cfg(input int sel, input logic [21:0] data);
        @(negedge clk);
        bus4.cfg_we = 1'b1; bus4.cfg_sel = 2'(sel); bus4.cfg_wdata = data;
        @(negedge clk);
        bus4.cfg_we = 1'b0;
    endtask

    // One transfer on the 4-slave DUT; k = XFER cycles before ctrl_done, tmo = never send done.
    task automatic run_xfer(input int cs, ts, th, tg, k, input logic cpol, cpha,
                            input logic [7:0] dvsr, input bit tmo,
                            input bit we, input int wsel, input logic [21:0] wdata);
        int a, x0, d, t;
        @(negedge clk);
        a = cyc + 1;
        bus4.req_valid = 1'b1; bus4.req_cs = 2'(cs);
        if (we) begin
            bus4.cfg_we = 1'b1; bus4.cfg_sel = 2'(wsel); bus4.cfg_wdata = wdata;
        end
        push(K_CS_ON, a, cs_pat(cs), 1'b0, 1'b0, 8'h0);
        push(K_START, a + ts, 4'hF, cpol, cpha, dvsr);
        @(negedge clk);
        bus4.req_valid = 1'b0; bus4.cfg_we = 1'b0;
        x0 = a + ts + 1;
        if (!tmo) begin
            repeat (x0 + k - a) @(negedge clk);
            bus4.ctrl_done = 1'b1;
            d = x0 + k + 1;
            push(K_CS_OFF, d + th, 4'hF, 1'b0, 1'b0, 8'h0);
            push(K_DONE, d + th, 4'hF, 1'b0, 1'b0, 8'h0);
            push(K_IDLE, d + th + tg, 4'hF, 1'b0, 1'b0, 8'h0);
            @(negedge clk);
            bus4.ctrl_done = 1'b0;
            repeat (th + tg) @(negedge clk);
        end else begin
            t = x0 + 16;
            push(K_TIMEOUT, t, 4'hF, 1'b0, 1'b0, 8'h0);
            push(K_CS_OFF, t + th, 4'hF, 1'b0, 1'b0, 8'h0);
            push(K_IDLE, t + th + tg, 4'hF, 1'b0, 1'b0, 8'h0);
            repeat (t + th + tg - a) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        bus4.cfg_we = 1'b0; bus4.cfg_sel = '0; bus4.cfg_wdata = '0;
        bus4.req_valid = 1'b0; bus4.req_cs = '0; bus4.ctrl_done = 1'b0;
        bus3.cfg_we = 1'b0; bus3.cfg_sel = '0; bus3.cfg_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_cs = '0; bus3.ctrl_done = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(bus4.cs_n), 32'hF);
        chk("rst_req_ready", 32'(bus4.req_ready), 32'h0);
        chk("rst_busy", 32'(bus4.busy), 32'h0);
        chk("rst_pulses", 32'({bus4.ctrl_start, bus4.req_err, bus4.xfer_done,
                               bus4.xfer_timeout}), 32'h0);
        chk("rst_ctrl", 32'({bus4.ctrl_cpol, bus4.ctrl_cpha, bus4.ctrl_dvsr}), 32'h001);
        chk("rst_cs_n3", 32'(bus3.cs_n), 32'h7);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(bus4.req_ready), 32'h1);

        // Out-of-range slave on the 3-slave instance.
        @(negedge clk);
        a = cyc + 1;
        bus3.req_valid = 1'b1; bus3.req_cs = 2'd3;
        push(K_ERR3, a, 4'hF, 1'b0, 1'b0, 8'h0);
        @(negedge clk);
        bus3.req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("err_cs_n3", 32'(bus3.cs_n), 32'h7);
            chk("err_busy3", 32'(bus3.busy), 32'h0);
        end

        // Reset-default entry on slave 2.
        run_xfer(2, 1, 1, 1, 2, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 0, '0);
        // Programmed slave 1: zero setup, long hold and gap.
        write_cfg(1, cfg(1'b1, 1'b1, 8'h20, 0, 3, 5));
        run_xfer(1, 0, 3, 5, 1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 0, '0);
        chk("ctrl_dvsr_held", 32'(bus4.ctrl_dvsr), 32'h20);
        // Same-edge write and accept on slave 0 uses the old value; the next request the new one.
        run_xfer(0, 1, 1, 1, 0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 0, cfg(1'b0, 1'b0, 8'h10, 1, 1, 1));
        run_xfer(0, 1, 1, 1, 0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0, '0);
        // Watchdog expiry on slave 3.
        run_xfer(3, 1, 1, 1, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 0, '0);
        // Maximum setup count on slave 2.
        write_cfg(2, cfg(1'b0, 1'b0, 8'h05, 15, 1, 1));
        run_xfer(2, 15, 1, 1, 3, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 0, '0);

        // Reset in the middle of XFER on slave 2.
        @(negedge clk);
        a = cyc + 1;
        bus4.req_valid = 1'b1; bus4.req_cs = 2'd2;
        push(K_CS_ON, a, 4'b1011, 1'b0, 1'b0, 8'h0);
        push(K_START, a + 15, 4'hF, 1'b0, 1'b0, 8'h05);
        @(negedge clk);
        bus4.req_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("xfer_cs_n", 32'(bus4.cs_n), 32'hB);
        chk("xfer_busy", 32'(bus4.busy), 32'h1);
        #2;
        reset = 1'b1;
        push(K_CS_OFF, a + 18, 4'hF, 1'b0, 1'b0, 8'h0);
        push(K_IDLE, a + 18, 4'hF, 1'b0, 1'b0, 8'h0);
        #1;
        chk("async_cs_n", 32'(bus4.cs_n), 32'hF);
        chk("async_busy", 32'(bus4.busy), 32'h0);
        chk("async_req_ready", 32'(bus4.req_ready), 32'h0);
        chk("async_dvsr", 32'(bus4.ctrl_dvsr), 32'h01);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Slave 1 was reprogrammed before reset; it must be back to defaults.
        run_xfer(1, 1, 1, 1, 1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 0, '0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
